// File: rtl/pong_rally_ctrl.sv
// Pong game-flow controller: serve delay, live play, point award, game over.
// Issues ball load/step strobes and detects paddle misses.
module pong_rally_ctrl #(
  parameter int DISPLAY_WIDTH  = 256,
  parameter int DISPLAY_HEIGHT = 240,
  parameter int BALL_SIZE      = 4,
  parameter int PADDLE_HEIGHT  = 32,
  parameter int SERVE_FRAMES   = 60,
  parameter int SCORE_FRAMES   = 90,
  parameter int WIN_SCORE      = 9
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       start,
  input  logic [8:0] ball_hpos,
  input  logic [8:0] ball_vpos,
  input  logic [8:0] lpaddle_vpos,
  input  logic [8:0] rpaddle_vpos,
  output logic       ball_load,
  output logic       ball_step,
  output logic       serve_dir,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       game_over,
  output logic       winner,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SERVE  = 3'd1,
    PLAY   = 3'd2,
    SCORED = 3'd3,
    OVER   = 3'd4
  } st_t;

  localparam int CMAX =
    (SERVE_FRAMES > SCORE_FRAMES) ? SERVE_FRAMES : SCORE_FRAMES;
  localparam int CW = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CW-1:0] SERVE_LD = CW'(SERVE_FRAMES - 1);
  localparam logic [CW-1:0] SCORE_LD = CW'(SCORE_FRAMES - 1);
  localparam logic [9:0] BS10 = 10'(BALL_SIZE);
  // A paddle taller than the playfield behaves like a full-height wall.
  localparam logic [9:0] PH10 = 10'((PADDLE_HEIGHT < DISPLAY_HEIGHT) ?
                                    PADDLE_HEIGHT : DISPLAY_HEIGHT);
  localparam logic [8:0] RIGHT_X = 9'(DISPLAY_WIDTH - BALL_SIZE);
  localparam logic [3:0] WIN = 4'(WIN_SCORE);

  st_t           st;
  logic [CW-1:0] cnt;

  logic [9:0] bv, lp, rp;
  logic       l_ovl, r_ovl, l_miss, r_miss;

  // Widened to 10 bits so paddle/ball extents near 511 do not wrap.
  assign bv = {1'b0, ball_vpos};
  assign lp = {1'b0, lpaddle_vpos};
  assign rp = {1'b0, rpaddle_vpos};

  assign l_ovl  = (bv + BS10 > lp) && (bv < lp + PH10);
  assign r_ovl  = (bv + BS10 > rp) && (bv < rp + PH10);
  assign l_miss = (ball_hpos == 9'd0) && !l_ovl;
  assign r_miss = (ball_hpos >= RIGHT_X) && !r_ovl;

  assign state = st;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st        <= IDLE;
      cnt       <= '0;
      ball_load <= 1'b0;
      ball_step <= 1'b0;
      serve_dir <= 1'b1;
      score_l   <= 4'd0;
      score_r   <= 4'd0;
      game_over <= 1'b0;
      winner    <= 1'b0;
    end else begin
      ball_load <= 1'b0;
      ball_step <= 1'b0;
      if (frame_tick) begin
        unique case (st)
          IDLE, OVER: begin
            if (start) begin
              score_l   <= 4'd0;
              score_r   <= 4'd0;
              serve_dir <= 1'b1;
              ball_load <= 1'b1;
              game_over <= 1'b0;
              cnt       <= SERVE_LD;
              st        <= SERVE;
            end
          end
          SERVE: begin
            if (cnt == '0) st <= PLAY;
            else cnt <= cnt - 1'b1;
          end
          PLAY: begin
            if (l_miss) begin
              if (score_r < WIN) score_r <= score_r + 4'd1;
              serve_dir <= 1'b0;
              cnt       <= SCORE_LD;
              st        <= SCORED;
            end else if (r_miss) begin
              if (score_l < WIN) score_l <= score_l + 4'd1;
              serve_dir <= 1'b1;
              cnt       <= SCORE_LD;
              st        <= SCORED;
            end else begin
              ball_step <= 1'b1;
            end
          end
          SCORED: begin
            if (cnt != '0) begin
              cnt <= cnt - 1'b1;
            end else if (score_l == WIN || score_r == WIN) begin
              game_over <= 1'b1;
              winner    <= (score_r == WIN);
              st        <= OVER;
            end else begin
              ball_load <= 1'b1;
              cnt       <= SERVE_LD;
              st        <= SERVE;
            end
          end
          default: st <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pong_rally_ctrl.sv
// Bench for pong_rally_ctrl: directed scenarios plus random play
// against a phase/remaining-ticks reference model.
module tb_pong_rally_ctrl;

  localparam int SF = 2;
  localparam int CF = 3;
  localparam int WS = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic [8:0] ball_hpos = '0;
  logic [8:0] ball_vpos = '0;
  logic [8:0] lpaddle_vpos = '0;
  logic [8:0] rpaddle_vpos = '0;
  logic       ball_load, ball_step, serve_dir;
  logic [3:0] score_l, score_r;
  logic       game_over, winner;
  logic [2:0] state;

  int total = 0;
  int bad = 0;

  int m_ph, m_left, m_sl, m_sr;
  bit m_dir, m_go, m_win, m_load, m_step;

  pong_rally_ctrl #(
    .SERVE_FRAMES(SF),
    .SCORE_FRAMES(CF),
    .WIN_SCORE(WS)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .frame_tick(frame_tick),
    .start(start),
    .ball_hpos(ball_hpos),
    .ball_vpos(ball_vpos),
    .lpaddle_vpos(lpaddle_vpos),
    .rpaddle_vpos(rpaddle_vpos),
    .ball_load(ball_load),
    .ball_step(ball_step),
    .serve_dir(serve_dir),
    .score_l(score_l),
    .score_r(score_r),
    .game_over(game_over),
    .winner(winner),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_ph = 0; m_left = 0; m_sl = 0; m_sr = 0;
    m_dir = 1; m_go = 0; m_win = 0; m_load = 0; m_step = 0;
  endtask

  // Phases: 0 idle, 1 serve, 2 play, 3 scored, 4 over.
  // m_left counts ticks still to spend in the timed phases.
  task automatic model_tick(input bit s, input int h, v, lp, rp);
    bit lm, rm;
    lm = (h == 0) && !((v + 4 > lp) && (v < lp + 32));
    rm = (h >= 252) && !((v + 4 > rp) && (v < rp + 32));
    m_load = 0;
    m_step = 0;
    if (m_ph == 0 || m_ph == 4) begin
      if (s) begin
        m_sl = 0; m_sr = 0; m_dir = 1; m_go = 0;
        m_load = 1; m_ph = 1; m_left = SF;
      end
    end else if (m_ph == 1) begin
      m_left--;
      if (m_left == 0) m_ph = 2;
    end else if (m_ph == 2) begin
      if (lm) begin
        if (m_sr < WS) m_sr++;
        m_dir = 0; m_ph = 3; m_left = CF;
      end else if (rm) begin
        if (m_sl < WS) m_sl++;
        m_dir = 1; m_ph = 3; m_left = CF;
      end else begin
        m_step = 1;
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        if (m_sl == WS || m_sr == WS) begin
          m_ph = 4; m_go = 1; m_win = (m_sr == WS);
        end else begin
          m_load = 1; m_ph = 1; m_left = SF;
        end
      end
    end
  endtask

  task automatic tick(input bit s, input int h, v, lp, rp);
    start = s;
    ball_hpos = 9'(h);
    ball_vpos = 9'(v);
    lpaddle_vpos = 9'(lp);
    rpaddle_vpos = 9'(rp);
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    start = 1'b0;
    model_tick(s, h, v, lp, rp);
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #4 reset_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (state !== 3'd0) begin
      bad++; $display("FAIL reset_state got %0d want 0", state);
    end
    total++;
    if ({ball_load, ball_step} !== 2'b00) begin
      bad++; $display("FAIL reset_strobes got %b want 00", {ball_load, ball_step});
    end
    total++;
    if ({serve_dir, score_l, score_r, game_over, winner} !== 11'b1_0000_0000_0_0) begin
      bad++;
      $display("FAIL reset_outs got %b want 10000000000",
               {serve_dir, score_l, score_r, game_over, winner});
    end
  endtask

  task automatic test_serve();
    tick(1, 100, 100, 100, 100);
    total++;
    if ({ball_load, serve_dir, score_l, score_r, state} !== {1'b1, 1'b1, 8'd0, 3'd1}) begin
      bad++;
      $display("FAIL serve_start load=%b dir=%b sl=%0d sr=%0d st=%0d want 1 1 0 0 1",
               ball_load, serve_dir, score_l, score_r, state);
    end
    idle_cycle();
    total++;
    if (ball_load !== 1'b0) begin
      bad++; $display("FAIL serve_load_width got %b want 0", ball_load);
    end
    tick(0, 100, 100, 100, 100);
    total++;
    if (state !== 3'd1 || ball_step !== 1'b0) begin
      bad++; $display("FAIL serve_hold st=%0d step=%b want 1 0", state, ball_step);
    end
    tick(0, 100, 100, 100, 100);
    total++;
    if (state !== 3'd2 || ball_step !== 1'b0) begin
      bad++; $display("FAIL serve_to_play st=%0d step=%b want 2 0", state, ball_step);
    end
  endtask

  task automatic test_play_steps();
    int steps = 0;
    for (int i = 0; i < 5; i++) begin
      tick(0, 100, 100, 100, 100);
      if (ball_step === 1'b1) steps++;
      idle_cycle();
      total++;
      if (ball_step !== 1'b0) begin
        bad++; $display("FAIL step_gap got %b want 0", ball_step);
      end
    end
    total++;
    if (steps != 5) begin
      bad++; $display("FAIL step_count got %0d want 5", steps);
    end
  endtask

  task automatic test_left_miss();
    tick(0, 0, 50, 30, 200);
    total++;
    if (ball_step !== 1'b1 || score_r !== 4'd0) begin
      bad++; $display("FAIL left_hit step=%b sr=%0d want 1 0", ball_step, score_r);
    end
    tick(0, 0, 50, 60, 200);
    total++;
    if ({score_r, serve_dir, ball_step, state} !== {4'd1, 1'b0, 1'b0, 3'd3}) begin
      bad++;
      $display("FAIL left_miss sr=%0d dir=%b step=%b st=%0d want 1 0 0 3",
               score_r, serve_dir, ball_step, state);
    end
    tick(0, 100, 100, 100, 100);
    tick(0, 100, 100, 100, 100);
    total++;
    if (state !== 3'd3 || ball_load !== 1'b0) begin
      bad++; $display("FAIL scored_hold st=%0d load=%b want 3 0", state, ball_load);
    end
    tick(0, 100, 100, 100, 100);
    total++;
    if (state !== 3'd1 || ball_load !== 1'b1) begin
      bad++; $display("FAIL scored_reserve st=%0d load=%b want 1 1", state, ball_load);
    end
    tick(0, 100, 100, 100, 100);
    tick(0, 100, 100, 100, 100);
  endtask

  task automatic test_right_miss();
    tick(0, 252, 10, 100, 200);
    total++;
    if ({score_l, serve_dir, state} !== {4'd1, 1'b1, 3'd3}) begin
      bad++;
      $display("FAIL right_miss sl=%0d dir=%b st=%0d want 1 1 3",
               score_l, serve_dir, state);
    end
    repeat (CF + SF) tick(0, 100, 100, 100, 100);
  endtask

  task automatic test_game_over();
    tick(0, 0, 50, 60, 200);
    total++;
    if (score_r !== 4'd2 || state !== 3'd3) begin
      bad++; $display("FAIL win_point sr=%0d st=%0d want 2 3", score_r, state);
    end
    repeat (CF) tick(0, 100, 100, 100, 100);
    total++;
    if ({game_over, winner, state, ball_load} !== {1'b1, 1'b1, 3'd4, 1'b0}) begin
      bad++;
      $display("FAIL over go=%b win=%b st=%0d load=%b want 1 1 4 0",
               game_over, winner, state, ball_load);
    end
    tick(0, 0, 50, 60, 200);
    total++;
    if ({state, score_l, score_r, ball_step} !== {3'd4, 4'd1, 4'd2, 1'b0}) begin
      bad++;
      $display("FAIL over_hold st=%0d sl=%0d sr=%0d step=%b want 4 1 2 0",
               state, score_l, score_r, ball_step);
    end
    tick(1, 100, 100, 100, 100);
    total++;
    if ({score_l, score_r, game_over, ball_load, state} !== {8'd0, 1'b0, 1'b1, 3'd1}) begin
      bad++;
      $display("FAIL restart sl=%0d sr=%0d go=%b load=%b st=%0d want 0 0 0 1 1",
               score_l, score_r, game_over, ball_load, state);
    end
  endtask

  task automatic test_right_boundary();
    repeat (SF) tick(0, 100, 100, 100, 100);
    tick(0, 252, 28, 100, 31);
    total++;
    if (ball_step !== 1'b1 || state !== 3'd2) begin
      bad++; $display("FAIL rbound_hit step=%b st=%0d want 1 2", ball_step, state);
    end
    tick(0, 252, 27, 100, 31);
    total++;
    if (score_l !== 4'd1 || state !== 3'd3) begin
      bad++; $display("FAIL rbound_miss sl=%0d st=%0d want 1 3", score_l, state);
    end
  endtask

  task automatic test_random();
    logic [15:0] got, exp;
    int h, v, lp, rp, sel, gaps;
    bit s;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      s = ($urandom_range(0, 3) == 0);
      sel = $urandom_range(0, 3);
      if (sel == 0) h = 0;
      else if (sel == 1) h = $urandom_range(248, 255);
      else h = $urandom_range(1, 247);
      v = $urandom_range(0, 511);
      lp = v + $urandom_range(0, 72) - 36;
      rp = v + $urandom_range(0, 72) - 36;
      if (lp < 0) lp = 0;
      if (lp > 511) lp = 511;
      if (rp < 0) rp = 0;
      if (rp > 511) rp = 511;
      tick(s, h, v, lp, rp);
      got = {state, ball_load, ball_step, serve_dir, score_l, score_r, game_over, winner};
      exp = {3'(m_ph), m_load, m_step, m_dir, 4'(m_sl), 4'(m_sr), m_go, m_win};
      total++;
      if (got !== exp) begin
        bad++; $display("FAIL rand_tick %0d got %h want %h", i, got, exp);
      end
      gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) begin
        idle_cycle();
        m_load = 0;
        m_step = 0;
        got = {state, ball_load, ball_step, serve_dir, score_l, score_r, game_over, winner};
        exp = {3'(m_ph), m_load, m_step, m_dir, 4'(m_sl), 4'(m_sr), m_go, m_win};
        total++;
        if (got !== exp) begin
          bad++; $display("FAIL rand_gap %0d got %h want %h", i, got, exp);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    tick(1, 100, 100, 100, 100);
    repeat (SF) tick(0, 100, 100, 100, 100);
    tick(0, 0, 50, 60, 200);
    tick(0, 100, 100, 100, 100);
    total++;
    if (state !== 3'd3) begin
      bad++; $display("FAIL arst_setup st=%0d want 3", state);
    end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({state, ball_load, ball_step, serve_dir, score_l, score_r, game_over, winner}
        !== {3'd0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL arst_scored st=%0d sr=%0d dir=%b want 0 0 1",
               state, score_r, serve_dir);
    end
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    tick(1, 100, 100, 100, 100);
    repeat (SF) tick(0, 100, 100, 100, 100);
    tick(0, 100, 100, 100, 100);
    total++;
    if (ball_step !== 1'b1 || state !== 3'd2) begin
      bad++; $display("FAIL arst_play_setup step=%b st=%0d want 1 2", ball_step, state);
    end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({state, ball_step, ball_load, serve_dir} !== {3'd0, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL arst_play st=%0d step=%b load=%b dir=%b want 0 0 0 1",
               state, ball_step, ball_load, serve_dir);
    end
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_serve();
    test_play_steps();
    test_left_miss();
    test_right_miss();
    test_game_over();
    test_right_boundary();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
